bsg_rx_decoder: RTL and testbench
=================================

# bsg_rx_decoder

Receive-side counterpart of the BSG transmit path. Hunts a serial bit stream for the sync byte, deserialises two payload bytes, optionally checks even parity, and exposes the result through the same 8-bit register-mapped bus style used by the TX protocol block. Sits between the RX line front-end (which supplies a bit strobe) and the host register bus.

## Interface
- DATA_WIDTH, 8: bus and payload byte width.
- SYNC_WORD, 8'hA5: frame sync pattern, MSB first.
- G_CLK_RX  input  1  RX clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- SER_IN  input  1  serial line data.
- BIT_VALID  input  1  qualifies SER_IN for one cycle; unqualified cycles are ignored.
- WRITE_ENABLE  input  1  register write strobe.
- READ_ENABLE  input  1  register read strobe.
- ADDR_IN  input  DATA_WIDTH  register address.
- DATA_IN  input  DATA_WIDTH  write data.
- DATA_OUT  output  DATA_WIDTH  registered read data.
- IRQ  output  1  frame-available interrupt.

## Operation
- Register map: 8'h20 STATUS (RO), 8'h21 RX_DATA_0 (RO), 8'h22 RX_DATA_1 (RO), 8'h23 CONTROL (RW).
- STATUS: bit0 VALID, bit1 OVERRUN, bit2 PARITY_ERR, bit3 BUSY (FSM not in HUNT); upper bits 0.
- CONTROL: bit0 RX_EN, bit1 CLR (write-1 clears OVERRUN and PARITY_ERR; self-clearing, reads 0), bit2 IRQ_EN; upper bits read 0.
- FSM states: HUNT, BYTE0, BYTE1, PARITY (PARITY exists only with macro).
- HUNT: each qualified bit shifts into an 8-bit window (LSB in); window == SYNC_WORD and RX_EN=1 -> BYTE0, bit counter 0.
- BYTE0/BYTE1: 8 qualified bits each, MSB first; counter 0..7 wraps, advancing the state at 7.
- Commit (after final bit): RX_DATA_0/1 loaded; VALID set; if VALID already 1 -> OVERRUN set, data still overwritten. Return to HUNT with window cleared to 0 (full sync must be re-received; no overlap reuse).
- Read of 8'h22 clears VALID. Commit in same cycle as that read: VALID stays 1, OVERRUN not set.
- RX_EN cleared mid-frame: FSM aborts to HUNT next edge, partial bytes discarded, flags untouched.
- IRQ = VALID & IRQ_EN, combinational from registers.
- Write: WRITE_ENABLE=1 at 8'h23 updates CONTROL; writes elsewhere ignored.
- Read: READ_ENABLE=1 -> DATA_OUT loads addressed register next edge; unmapped address -> 0. Both strobes high: write only, DATA_OUT holds. Neither: DATA_OUT holds.

## Timing
- Reset: DATA_OUT=0, IRQ=0, all registers 0 (RX_EN=0), FSM HUNT, window 0, counter 0.
- Read latency 1 cycle; back-to-back reads every cycle.
- VALID/RX_DATA visible one cycle after the edge sampling the final frame bit.
- Minimum frame: 8 sync + 16 data qualified bits (+1 parity with macro).
- Reset assertion mid-frame returns all state to reset values immediately.

## Configuration
- BSG_RX_PARITY_EN defined: frame carries one trailing bit; even parity over 16 payload bits (bit = XOR of payload). Mismatch -> frame discarded, PARITY_ERR set, VALID/RX_DATA unchanged, FSM to HUNT.
- Undefined: no PARITY state; commit after BYTE1 bit 7; PARITY_ERR reads 0.

## Test plan
- Reset, read 8'h20/8'h23 -> DATA_OUT 8'h00; IRQ 0.
- Write 8'h23=8'h05, send A5,3C,C3 (plus parity 0 with macro) -> STATUS 8'h01, 8'h21 reads 3C, 8'h22 reads C3, IRQ high; STATUS then 8'h00.
- Two frames (11,22 then 33,44) without reads -> STATUS 8'h03, data 33/44; write 8'h23=8'h07 -> OVERRUN cleared.
- RX_EN=0 after sync and 4 bits, then RX_EN=1 and a full frame 55,AA -> only 55/AA captured, no OVERRUN.
- Macro on: A5,01,00, parity 0 -> STATUS 8'h04, VALID 0; CLR -> 8'h00.
- Gaps of BIT_VALID=0 between every bit, and a read of 8'h22 on commit cycle -> same data, VALID=1, OVERRUN=0.

Source files
------------

// File: rtl/bsg_rx_decoder.sv
// Receive-side frame decoder: hunts the sync byte, deserialises two payload bytes and exposes them on the register bus.
// Define BSG_RX_PARITY_EN to expect and check a trailing even-parity bit after the payload.
module bsg_rx_decoder #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_WORD  = DATA_WIDTH'(8'hA5)
) (
  input  logic                  G_CLK_RX,
  input  logic                  rst,
  input  logic                  SER_IN,
  input  logic                  BIT_VALID,
  input  logic                  WRITE_ENABLE,
  input  logic                  READ_ENABLE,
  input  logic [DATA_WIDTH-1:0] ADDR_IN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  IRQ
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned PAY_W = 2 * DATA_WIDTH;

  localparam logic [DATA_WIDTH-1:0] ADDR_STATUS  = DATA_WIDTH'(8'h20);
  localparam logic [DATA_WIDTH-1:0] ADDR_DATA0   = DATA_WIDTH'(8'h21);
  localparam logic [DATA_WIDTH-1:0] ADDR_DATA1   = DATA_WIDTH'(8'h22);
  localparam logic [DATA_WIDTH-1:0] ADDR_CONTROL = DATA_WIDTH'(8'h23);
  localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(DATA_WIDTH - 1);

`ifdef BSG_RX_PARITY_EN
  typedef enum logic [1:0] {S_HUNT, S_BYTE0, S_BYTE1, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_HUNT, S_BYTE0, S_BYTE1} state_t;
`endif

  state_t                  state;
  logic [DATA_WIDTH-1:0]   window;
  logic [CNT_W-1:0]        bit_cnt;
  logic [PAY_W-1:0]        payload;

  logic                    valid;
  logic                    overrun;
  logic                    parity_err;
  logic                    rx_en;
  logic                    irq_en;
  logic [DATA_WIDTH-1:0]   rx_data_0;
  logic [DATA_WIDTH-1:0]   rx_data_1;

  logic [DATA_WIDTH-1:0]   window_shift;
  logic [PAY_W-1:0]        payload_shift;
  logic [PAY_W-1:0]        commit_data;
  logic                    last_bit;
  logic                    busy;
  logic                    commit;
  logic                    ctrl_wr;
  logic                    ctrl_clr;
  logic                    rd_go;
  logic                    rd_data1;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    unused_bits;

  assign window_shift  = {window[DATA_WIDTH-2:0], SER_IN};
  assign payload_shift = {payload[PAY_W-2:0], SER_IN};
  assign last_bit      = (bit_cnt == CNT_LAST);
  assign busy          = (state != S_HUNT);
  assign ctrl_wr       = WRITE_ENABLE && (ADDR_IN == ADDR_CONTROL);
  assign ctrl_clr      = ctrl_wr && DATA_IN[1];
  assign rd_go         = READ_ENABLE && !WRITE_ENABLE;
  assign rd_data1      = rd_go && (ADDR_IN == ADDR_DATA1);
  assign IRQ           = valid & irq_en;

`ifdef BSG_RX_PARITY_EN
  logic parity_fail;

  // Frame completes on the parity bit; payload is already fully shifted in.
  always_comb begin
    commit      = 1'b0;
    parity_fail = 1'b0;
    commit_data = payload;
    if (rx_en && BIT_VALID && (state == S_PARITY)) begin
      if (SER_IN == ^payload) begin
        commit = 1'b1;
      end else begin
        parity_fail = 1'b1;
      end
    end
  end

  always_ff @(posedge G_CLK_RX or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else begin
      if (ctrl_clr) begin
        parity_err <= 1'b0;
      end
      if (parity_fail) begin
        parity_err <= 1'b1;
      end
    end
  end

  assign unused_bits = ^{DATA_IN[DATA_WIDTH-1:3], window[DATA_WIDTH-1]};
`else
  // Frame completes on the last payload bit, which is still in flight on SER_IN.
  always_comb begin
    commit      = 1'b0;
    commit_data = payload_shift;
    if (rx_en && BIT_VALID && (state == S_BYTE1) && last_bit) begin
      commit = 1'b1;
    end
  end

  assign parity_err  = 1'b0;
  assign unused_bits = ^{DATA_IN[DATA_WIDTH-1:3], window[DATA_WIDTH-1], payload[PAY_W-1]};
`endif

  // Sync hunt and payload deserialiser; clearing RX_EN abandons any partial frame.
  always_ff @(posedge G_CLK_RX or negedge rst) begin
    if (!rst) begin
      state   <= S_HUNT;
      window  <= '0;
      bit_cnt <= '0;
      payload <= '0;
    end else begin
      case (state)
        S_HUNT: begin
          if (BIT_VALID) begin
            window <= window_shift;
            if (rx_en && (window_shift == SYNC_WORD)) begin
              state   <= S_BYTE0;
              bit_cnt <= '0;
            end
          end
        end
        S_BYTE0, S_BYTE1: begin
          if (!rx_en) begin
            state   <= S_HUNT;
            window  <= '0;
            bit_cnt <= '0;
          end else if (BIT_VALID) begin
            payload <= payload_shift;
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            if (last_bit) begin
              if (state == S_BYTE0) begin
                state <= S_BYTE1;
              end else begin
`ifdef BSG_RX_PARITY_EN
                state <= S_PARITY;
`else
                state  <= S_HUNT;
                window <= '0;
`endif
              end
            end
          end
        end
`ifdef BSG_RX_PARITY_EN
        S_PARITY: begin
          if (!rx_en || BIT_VALID) begin
            state   <= S_HUNT;
            window  <= '0;
            bit_cnt <= '0;
          end
        end
`endif
        default: begin
          state   <= S_HUNT;
          window  <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Status flags, captured data and control; a new event wins over a same-cycle clear.
  always_ff @(posedge G_CLK_RX or negedge rst) begin
    if (!rst) begin
      valid     <= 1'b0;
      overrun   <= 1'b0;
      rx_en     <= 1'b0;
      irq_en    <= 1'b0;
      rx_data_0 <= '0;
      rx_data_1 <= '0;
    end else begin
      if (ctrl_wr) begin
        rx_en  <= DATA_IN[0];
        irq_en <= DATA_IN[2];
      end
      if (ctrl_clr) begin
        overrun <= 1'b0;
      end
      if (commit) begin
        valid     <= 1'b1;
        rx_data_0 <= commit_data[PAY_W-1 -: DATA_WIDTH];
        rx_data_1 <= commit_data[DATA_WIDTH-1:0];
        if (valid && !rd_data1) begin
          overrun <= 1'b1;
        end
      end else if (rd_data1) begin
        valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ADDR_IN)
      ADDR_STATUS:  rd_mux = DATA_WIDTH'({busy, parity_err, overrun, valid});
      ADDR_DATA0:   rd_mux = rx_data_0;
      ADDR_DATA1:   rd_mux = rx_data_1;
      ADDR_CONTROL: rd_mux = DATA_WIDTH'({irq_en, 1'b0, rx_en});
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge G_CLK_RX or negedge rst) begin
    if (!rst) begin
      DATA_OUT <= '0;
    end else if (rd_go) begin
      DATA_OUT <= rd_mux;
    end
  end

endmodule

// File: tb/tb_bsg_rx_decoder.sv
// Bench for bsg_rx_decoder: directed protocol steps plus random frames, each cycle compared
// against a bit-queue reference model of the receiver.
module tb_bsg_rx_decoder;

  logic       G_CLK_RX = 1'b0;
  logic       rst;
  logic       SER_IN;
  logic       BIT_VALID;
  logic       WRITE_ENABLE;
  logic       READ_ENABLE;
  logic [7:0] ADDR_IN;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       IRQ;

  int checks = 0;
  int errors = 0;

`ifdef BSG_RX_PARITY_EN
  localparam int FRAME_BITS = 17;
`else
  localparam int FRAME_BITS = 16;
`endif

  bsg_rx_decoder #(.DATA_WIDTH(8), .SYNC_WORD(8'hA5)) dut (
    .G_CLK_RX     (G_CLK_RX),
    .rst          (rst),
    .SER_IN       (SER_IN),
    .BIT_VALID    (BIT_VALID),
    .WRITE_ENABLE (WRITE_ENABLE),
    .READ_ENABLE  (READ_ENABLE),
    .ADDR_IN      (ADDR_IN),
    .DATA_IN      (DATA_IN),
    .DATA_OUT     (DATA_OUT),
    .IRQ          (IRQ)
  );

  always #5 G_CLK_RX = ~G_CLK_RX;

  // Reference model state
  bit         m_hunt;
  logic [7:0] m_win;
  bit         m_bits[$];
  bit         m_en, m_ien, m_valid, m_ovr, m_perr;
  logic [7:0] m_d0, m_d1, m_dout;

  task automatic m_reset();
    m_hunt = 1'b1; m_win = 8'h00; m_bits.delete();
    m_en = 1'b0; m_ien = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    m_d0 = 8'h00; m_d1 = 8'h00; m_dout = 8'h00;
  endtask

  function automatic logic [7:0] m_reg(input logic [7:0] a);
    case (a)
      8'h20:   return {4'b0000, !m_hunt, m_perr, m_ovr, m_valid};
      8'h21:   return m_d0;
      8'h22:   return m_d1;
      8'h23:   return {5'b00000, m_ien, 1'b0, m_en};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge(input logic ser, bv, we, re, input logic [7:0] addr, din);
    bit          rd, clrv, commit, pfail;
    logic [15:0] pl;
    rd = re && !we;
    clrv = rd && (addr == 8'h22);
    commit = 1'b0;
    pfail = 1'b0;
    pl = 16'h0000;
    if (rd) m_dout = m_reg(addr);
    if (!m_hunt && !m_en) begin
      m_hunt = 1'b1; m_win = 8'h00; m_bits.delete();
    end else if (bv) begin
      if (m_hunt) begin
        m_win = {m_win[6:0], ser};
        if (m_en && m_win == 8'hA5) begin
          m_hunt = 1'b0; m_bits.delete();
        end
      end else begin
        m_bits.push_back(ser);
        if (m_bits.size() == FRAME_BITS) begin
          for (int i = 0; i < 16; i++) pl = {pl[14:0], m_bits[i]};
          commit = 1'b1;
`ifdef BSG_RX_PARITY_EN
          if (m_bits[16] != ^pl) begin
            commit = 1'b0; pfail = 1'b1;
          end
`endif
          m_hunt = 1'b1; m_win = 8'h00; m_bits.delete();
        end
      end
    end
    if (we && addr == 8'h23 && din[1]) begin
      m_ovr = 1'b0; m_perr = 1'b0;
    end
    if (commit) begin
      if (m_valid && !clrv) m_ovr = 1'b1;
      m_valid = 1'b1; m_d0 = pl[15:8]; m_d1 = pl[7:0];
    end else if (clrv) begin
      m_valid = 1'b0;
    end
    if (pfail) m_perr = 1'b1;
    if (we && addr == 8'h23) begin
      m_en = din[0]; m_ien = din[2];
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ser, bv, we, re, input logic [7:0] addr, din);
    SER_IN = ser; BIT_VALID = bv; WRITE_ENABLE = we; READ_ENABLE = re;
    ADDR_IN = addr; DATA_IN = din;
    model_edge(ser, bv, we, re, addr, din);
    @(posedge G_CLK_RX);
    #1;
    chk("dout", DATA_OUT, m_dout);
    chk("irq", {7'b0, IRQ}, {7'b0, m_valid & m_ien});
  endtask

  task automatic idle();
    step(1'($urandom), 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, 1'b0, addr, d);
  endtask

  task automatic rd_exp(input logic [7:0] addr, input logic [7:0] exp, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b1, addr, 8'h00);
    chk(tag, DATA_OUT, exp);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i >= 8 - n; i--) step(v[i], 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Whole frame: sync, two bytes MSB first, optional parity; optional gaps and a read of 8'h22 on the final bit.
  task automatic send_frame(input logic [7:0] b0, b1, input bit gaps, rd_last, bad_par);
    bit         q[$];
    logic [7:0] s;
    logic       par;
    s = 8'hA5;
    for (int i = 7; i >= 0; i--) q.push_back(s[i]);
    for (int i = 7; i >= 0; i--) q.push_back(b0[i]);
    for (int i = 7; i >= 0; i--) q.push_back(b1[i]);
    par = (^{b0, b1}) ^ bad_par;
    if (FRAME_BITS == 17) q.push_back(par);
    for (int i = 0; i < q.size(); i++) begin
      step(q[i], 1'b1, 1'b0, rd_last && (i == q.size() - 1), 8'h22, 8'h00);
      if (gaps && i != q.size() - 1) repeat ($urandom_range(1, 3)) idle();
    end
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b0; SER_IN = 1'b0; BIT_VALID = 1'b0; WRITE_ENABLE = 1'b0; READ_ENABLE = 1'b0;
    ADDR_IN = 8'h00; DATA_IN = 8'h00;
    m_reset();
    repeat (2) @(posedge G_CLK_RX);
    #1;
    chk("rst_dout", DATA_OUT, 8'h00);
    chk("rst_irq", {7'b0, IRQ}, 8'h00);
    rst = 1'b1;
    rd_exp(8'h20, 8'h00, "status_rst");
    rd_exp(8'h23, 8'h00, "ctrl_rst");

    // Basic frame
    wr(8'h23, 8'h05);
    send_frame(8'h3C, 8'hC3, 1'b0, 1'b0, 1'b0);
    rd_exp(8'h20, 8'h01, "status_valid");
    chk("irq_high", {7'b0, IRQ}, 8'h01);
    rd_exp(8'h21, 8'h3C, "data0");
    rd_exp(8'h22, 8'hC3, "data1");
    rd_exp(8'h20, 8'h00, "status_cleared");
    chk("irq_low", {7'b0, IRQ}, 8'h00);
    rd_exp(8'h23, 8'h05, "ctrl_rb");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'hFF);
    chk("both_strobes_hold", DATA_OUT, 8'h05);
    rd_exp(8'h20, 8'h00, "ro_write_ignored");

    // Overrun
    send_frame(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    rd_exp(8'h20, 8'h03, "status_overrun");
    rd_exp(8'h21, 8'h33, "ovr_data0");
    wr(8'h23, 8'h07);
    rd_exp(8'h20, 8'h01, "ovr_clr");
    rd_exp(8'h22, 8'h44, "ovr_data1");
    rd_exp(8'h20, 8'h00, "status_idle");
    rd_exp(8'h23, 8'h05, "clr_self_clears");

    // Abort mid-frame
    send_bits(8'hA5, 8);
    send_bits(8'hF0, 4);
    rd_exp(8'h20, 8'h08, "status_busy");
    wr(8'h23, 8'h04);
    idle();
    rd_exp(8'h20, 8'h00, "status_abort");
    wr(8'h23, 8'h05);
    send_frame(8'h55, 8'hAA, 1'b0, 1'b0, 1'b0);
    rd_exp(8'h20, 8'h01, "abort_status");
    rd_exp(8'h21, 8'h55, "abort_data0");
    rd_exp(8'h22, 8'hAA, "abort_data1");

`ifdef BSG_RX_PARITY_EN
    send_frame(8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    rd_exp(8'h20, 8'h04, "parity_err");
    wr(8'h23, 8'h07);
    rd_exp(8'h20, 8'h00, "parity_clr");
`endif

    // Gapped frame committing on the cycle VALID is read away
    send_frame(8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(8'h96, 8'h69, 1'b1, 1'b1, 1'b0);
    chk("rd_on_commit_old", DATA_OUT, 8'hC3);
    rd_exp(8'h20, 8'h01, "rd_on_commit_status");
    rd_exp(8'h21, 8'h96, "gap_data0");
    rd_exp(8'h22, 8'h69, "gap_data1");

    // Reset mid-frame
    send_frame(8'h77, 8'h88, 1'b0, 1'b0, 1'b0);
    rd_exp(8'h21, 8'h77, "pre_rst_data0");
    send_bits(8'hA5, 8);
    send_bits(8'h12, 3);
    #3 rst = 1'b0;
    #1;
    chk("midrst_dout", DATA_OUT, 8'h00);
    chk("midrst_irq", {7'b0, IRQ}, 8'h00);
    m_reset();
    @(posedge G_CLK_RX);
    #1 rst = 1'b1;
    rd_exp(8'h20, 8'h00, "status_after_rst");
    rd_exp(8'h23, 8'h00, "ctrl_after_rst");

    // Randomized traffic against the model
    wr(8'h23, 8'h05);
    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(0, 4)) step(1'($urandom), 1'($urandom), 1'b0, 1'b0, 8'h00, 8'h00);
      case ($urandom_range(0, 5))
        0: step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom_range(8'h20, 8'h24)), 8'h00);
        1: begin
          d = 8'($urandom);
          d[0] = ($urandom_range(0, 7) != 0);
          wr(8'h23, d);
        end
        2: step(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), 8'h00);
        default: ;
      endcase
      send_frame(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 8'h00);
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
